// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and helpers for the SDRAM port arbiter.
//   master_id_t : 1-bit identifier of an accelerator master port
//   ID_M0/ID_M1 : m0 = weight/bias reader, m1 = activation reader/writer
//   clog2()     : ceiling log2, used to size the tag FIFO pointers/count
package sdram_arb_pkg;

   typedef logic master_id_t;

   localparam master_id_t ID_M0 = 1'b0;
   localparam master_id_t ID_M1 = 1'b1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: synchronous FIFO of 1-bit master IDs, used to route
// pipelined read returns back to the master that issued the read.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (clears to empty)
//   push, push_id    enqueue an ID (caller must not push while full)
//   pop              dequeue the head (caller must not pop while empty)
//   head_id          ID at the head of the queue
//   full, empty      occupancy flags
//   count            number of stored IDs (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module arb_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  master_id_t              push_id,
   input  logic                    pop,
   output master_id_t              head_id,
   output logic                    full,
   output logic                    empty,
   output logic [clog2(DEPTH):0]   count
);

   localparam int PW = clog2(DEPTH);
   localparam int CW = PW + 1;

   master_id_t    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         // simultaneous push and pop leaves the occupancy unchanged
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_id = mem[rd_ptr];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller Avalon-MM slave between
// two accelerator masters (m0 weight/bias reader, m1 activation reader/writer).
// Commands are granted round-robin and forwarded; read returns are routed
// back in order through a tag FIFO of issuing master IDs.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   m0_* / m1_*                    Avalon-MM master-side command/return ports
//   s_*                            Avalon-MM slave-side ports to the controller
//   err_spurious                   sticky: read data arrived with no read pending
// Optional build macro ARB_PERF_CNT_EN adds m0_grant_cnt, m1_grant_cnt and
// stall_cnt performance counters (32-bit, wrapping).
//
// Handshake: a command transfers (is "accepted") in a cycle where s_read or
// s_write is high and s_waitrequest is low; the master sees the same event as
// its command asserted with its waitrequest low. Stalled masters hold their
// command stable, so the grant is only ever moved on an accept or from idle.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int MAX_PENDING = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   m0_address,
   input  logic            m0_read,
   input  logic            m0_write,
   input  logic [DW-1:0]   m0_writedata,
   input  logic [DW/8-1:0] m0_byteenable,
   output logic            m0_waitrequest,
   output logic [DW-1:0]   m0_readdata,
   output logic            m0_readdatavalid,
   input  logic [AW-1:0]   m1_address,
   input  logic            m1_read,
   input  logic            m1_write,
   input  logic [DW-1:0]   m1_writedata,
   input  logic [DW/8-1:0] m1_byteenable,
   output logic            m1_waitrequest,
   output logic [DW-1:0]   m1_readdata,
   output logic            m1_readdatavalid,
   output logic [AW-1:0]   s_address,
   output logic            s_read,
   output logic            s_write,
   output logic [DW-1:0]   s_writedata,
   output logic [DW/8-1:0] s_byteenable,
   input  logic            s_waitrequest,
   input  logic [DW-1:0]   s_readdata,
   input  logic            s_readdatavalid,
   output logic            err_spurious
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]     m0_grant_cnt,
   output logic [31:0]     m1_grant_cnt,
   output logic [31:0]     stall_cnt
`endif
);

   localparam int CW = clog2(MAX_PENDING) + 1;

   logic          gnt_valid, gnt_valid_nxt;
   master_id_t    gnt_id, gnt_id_nxt;
   master_id_t    last_id, last_id_nxt;

   logic          req0, req1, req0_eff, req1_eff;
   logic          g_read, g_write, g_wait;
   logic          throttle, accept;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   master_id_t    fifo_head;
   logic [CW-1:0] fifo_count;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // Command mux: the granted master drives the slave side.
   assign g_read       = (gnt_id == ID_M1) ? m1_read       : m0_read;
   assign g_write      = (gnt_id == ID_M1) ? m1_write      : m0_write;
   assign s_address    = (gnt_id == ID_M1) ? m1_address    : m0_address;
   assign s_writedata  = (gnt_id == ID_M1) ? m1_writedata  : m0_writedata;
   assign s_byteenable = (gnt_id == ID_M1) ? m1_byteenable : m0_byteenable;

   // A read is held back while every tag slot is taken; a same-cycle pop
   // does not release it until the count has actually dropped.
   assign throttle = gnt_valid & g_read & (fifo_count == CW'(MAX_PENDING));

   assign s_read  = gnt_valid & g_read & ~throttle;
   assign s_write = gnt_valid & g_write;
   assign g_wait  = s_waitrequest | throttle;

   assign m0_waitrequest = ~(gnt_valid & (gnt_id == ID_M0)) | g_wait;
   assign m1_waitrequest = ~(gnt_valid & (gnt_id == ID_M1)) | g_wait;

   assign accept = (s_read | s_write) & ~s_waitrequest;

   // On an accept the granted master's inputs still show the command being
   // accepted, so it only competes again once it presents a new one.
   assign req0_eff = req0 & ~(gnt_valid & (gnt_id == ID_M0));
   assign req1_eff = req1 & ~(gnt_valid & (gnt_id == ID_M1));

   always_comb begin
      gnt_valid_nxt = gnt_valid;
      gnt_id_nxt    = gnt_id;
      last_id_nxt   = last_id;
      if (accept) last_id_nxt = gnt_id;
      if (!gnt_valid || accept) begin
         if (req0_eff && req1_eff) begin
            gnt_valid_nxt = 1'b1;
            gnt_id_nxt    = ~last_id;
         end else if (req0_eff) begin
            gnt_valid_nxt = 1'b1;
            gnt_id_nxt    = ID_M0;
         end else if (req1_eff) begin
            gnt_valid_nxt = 1'b1;
            gnt_id_nxt    = ID_M1;
         end else begin
            gnt_valid_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_valid <= 1'b0;
         gnt_id    <= ID_M0;
         last_id   <= ID_M1;  // so m0 wins the first tie
      end else begin
         gnt_valid <= gnt_valid_nxt;
         gnt_id    <= gnt_id_nxt;
         last_id   <= last_id_nxt;
      end
   end

   // Read-return routing.
   assign fifo_push = accept & s_read & ~fifo_full;
   assign fifo_pop  = s_readdatavalid & ~fifo_empty;

   arb_tag_fifo #(
      .DEPTH (MAX_PENDING)
   ) u_tag_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (fifo_push),
      .push_id (gnt_id),
      .pop     (fifo_pop),
      .head_id (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = fifo_pop & (fifo_head == ID_M0);
   assign m1_readdatavalid = fifo_pop & (fifo_head == ID_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_spurious <= 1'b0;
      end else if (s_readdatavalid && fifo_empty) begin
         err_spurious <= 1'b1;
      end
   end

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_grant_cnt <= '0;
         m1_grant_cnt <= '0;
         stall_cnt    <= '0;
      end else begin
         if (accept && (gnt_id == ID_M0)) m0_grant_cnt <= m0_grant_cnt + 32'd1;
         if (accept && (gnt_id == ID_M1)) m1_grant_cnt <= m1_grant_cnt + 32'd1;
         if ((req0 || req1) && !accept)   stall_cnt    <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed bench for sdram_port_arbiter. Stimulus
// pushes expected slave-side commands and expected read returns into queues;
// a negedge monitor pops and compares whenever the DUT presents a command
// accept or a master readdatavalid. Timing-specific behaviour (stalls,
// throttle, reset, sticky error) is checked directly in the stimulus.
module tb_sdram_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MAXP = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [AW-1:0]   m0_address, m1_address;
   logic            m0_read, m0_write, m1_read, m1_write;
   logic [DW-1:0]   m0_writedata, m1_writedata;
   logic [DW/8-1:0] m0_byteenable, m1_byteenable;
   logic            m0_waitrequest, m1_waitrequest;
   logic [DW-1:0]   m0_readdata, m1_readdata;
   logic            m0_readdatavalid, m1_readdatavalid;
   logic [AW-1:0]   s_address;
   logic            s_read, s_write;
   logic [DW-1:0]   s_writedata;
   logic [DW/8-1:0] s_byteenable;
   logic            s_waitrequest;
   logic [DW-1:0]   s_readdata;
   logic            s_readdatavalid;
   logic            err_spurious;

   sdram_port_arbiter #(
      .AW (AW), .DW (DW), .MAX_PENDING (MAXP)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_byteenable    (m0_byteenable),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_byteenable    (m1_byteenable),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .s_address        (s_address),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_waitrequest    (s_waitrequest),
      .s_readdata       (s_readdata),
      .s_readdatavalid  (s_readdatavalid),
      .err_spurious     (err_spurious)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [64:0] exp_cmd_q[$];  // {is_write, address, writedata}
   logic [32:0] exp_rd_q[$];   // {master_id, readdata}
   int          acc_cyc_q[$];  // cycle numbers of observed accepts

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      s_waitrequest = 1'b0; s_readdatavalid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic master_cmd(input int id, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, output int waits);
      if (id == 0) begin
         m0_address = addr; m0_read = !wr; m0_write = wr;
         m0_writedata = wd; m0_byteenable = 4'hF;
      end else begin
         m1_address = addr; m1_read = !wr; m1_write = wr;
         m1_writedata = wd; m1_byteenable = 4'hF;
      end
      waits = 0;
      @(negedge clk);
      while (((id == 0) ? m0_waitrequest : m1_waitrequest) && waits < 100) begin
         waits++;
         @(negedge clk);
      end
      if (waits >= 100) begin
         checks++;
         errors++;
         $display("FAIL cmd_timeout: master %0d stalled %0d cycles, required accept", id, waits);
      end
      @(posedge clk);
      #1;
      if (id == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
      else begin m1_read = 1'b0; m1_write = 1'b0; end
   endtask

   task automatic slave_return(input logic [31:0] d);
      s_readdata      = d;
      s_readdatavalid = 1'b1;
      tick();
      s_readdatavalid = 1'b0;
   endtask

   // ---------------- monitor ----------------
   logic [64:0] mon_cmd;
   logic [32:0] mon_rd;
   always @(negedge clk) begin
      if (rst_n) begin
         if ((s_read || s_write) && !s_waitrequest) begin
            acc_cyc_q.push_back(cyc);
            if (exp_cmd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL cmd_unexpected: got addr 0x%08h expected no command", s_address);
            end else begin
               mon_cmd = exp_cmd_q.pop_front();
               check("cmd_kind", {31'd0, s_write}, {31'd0, mon_cmd[64]});
               check("cmd_addr", s_address, mon_cmd[63:32]);
               if (mon_cmd[64]) check("cmd_wdata", s_writedata, mon_cmd[31:0]);
            end
         end
         if (m0_readdatavalid || m1_readdatavalid) begin
            if (m0_readdatavalid && m1_readdatavalid) begin
               checks++;
               errors++;
               $display("FAIL rdv_both: got both readdatavalid expected one");
            end
            if (exp_rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_unexpected: got m0_rdv=%0b m1_rdv=%0b expected none",
                        m0_readdatavalid, m1_readdatavalid);
            end else begin
               mon_rd = exp_rd_q.pop_front();
               check("rd_master", {31'd0, m1_readdatavalid}, {31'd0, mon_rd[32]});
               check("rd_data", m1_readdatavalid ? m1_readdata : m0_readdata, mon_rd[31:0]);
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   int w, w0, w1;
   logic [31:0] a;

   initial begin
      m0_address = '0; m1_address = '0; m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      m0_writedata = '0; m1_writedata = '0; m0_byteenable = '0; m1_byteenable = '0;
      s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;

      // reset state
      @(negedge clk);
      check("rst_s_read", {31'd0, s_read}, 32'd0);
      check("rst_s_write", {31'd0, s_write}, 32'd0);
      check("rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
      check("rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
      check("rst_m0_rdv", {31'd0, m0_readdatavalid}, 32'd0);
      check("rst_m1_rdv", {31'd0, m1_readdatavalid}, 32'd0);
      check("rst_err", {31'd0, err_spurious}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // T1: single m0 read, return 3 cycles after accept
      exp_cmd_q.push_back({1'b0, 32'h0000_0100, 32'h0});
      master_cmd(0, 1'b0, 32'h0000_0100, 32'h0, w);
      check("t1_grant_latency", w, 32'd1);
      tick();
      tick();
      exp_rd_q.push_back({1'b0, 32'hDEAD_BEEF});
      slave_return(32'hDEAD_BEEF);
      tick();
      check("t1_rd_done", exp_rd_q.size(), 32'd0);

      // T2: both masters stream reads, strict alternation, no idle cycles
      do_reset();
      acc_cyc_q.delete();
      for (int i = 0; i < 3; i++) begin
         a = 32'h0000_1000 + 32'(i * 4);
         exp_cmd_q.push_back({1'b0, a, 32'h0});
         a = 32'h0000_2000 + 32'(i * 4);
         exp_cmd_q.push_back({1'b0, a, 32'h0});
      end
      fork
         begin
            for (int i = 0; i < 3; i++) master_cmd(0, 1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0, w0);
         end
         begin
            for (int i = 0; i < 3; i++) master_cmd(1, 1'b0, 32'h0000_2000 + 32'(i * 4), 32'h0, w1);
         end
      join
      check("t2_accepts", acc_cyc_q.size(), 32'd6);
      for (int i = 1; i < acc_cyc_q.size(); i++)
         check("t2_no_gap", acc_cyc_q[i] - acc_cyc_q[i-1], 32'd1);
      for (int i = 0; i < 6; i++) begin
         a = 32'hA000_0000 + 32'(i);
         exp_rd_q.push_back({(i % 2 == 1), a});
         slave_return(a);
      end
      check("t2_rd_done", exp_rd_q.size(), 32'd0);

      // T3: m1 write stalled 4 cycles while m0 waits
      do_reset();
      exp_cmd_q.push_back({1'b1, 32'h0000_0040, 32'hCAFE_0040});
      exp_cmd_q.push_back({1'b0, 32'h0000_0100, 32'h0});
      m1_address = 32'h0000_0040; m1_write = 1'b1; m1_writedata = 32'hCAFE_0040; m1_byteenable = 4'hF;
      s_waitrequest = 1'b1;
      tick();
      m0_address = 32'h0000_0100; m0_read = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t3_hold_write", {31'd0, s_write}, 32'd1);
         check("t3_hold_addr", s_address, 32'h0000_0040);
         check("t3_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
         check("t3_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
         tick();
      end
      s_waitrequest = 1'b0;
      @(negedge clk);
      check("t3_m1_accept", {31'd0, m1_waitrequest}, 32'd0);
      check("t3_m0_still_wait", {31'd0, m0_waitrequest}, 32'd1);
      tick();
      m1_write = 1'b0;
      @(negedge clk);
      check("t3_m0_accept", {31'd0, m0_waitrequest}, 32'd0);
      check("t3_m0_sread", {31'd0, s_read}, 32'd1);
      tick();
      m0_read = 1'b0;
      exp_rd_q.push_back({1'b0, 32'h1111_0100});
      slave_return(32'h1111_0100);
      check("t3_rd_done", exp_rd_q.size(), 32'd0);

      // T4: read throttle at MAX_PENDING outstanding
      do_reset();
      for (int i = 0; i < MAXP; i++) begin
         a = 32'h0000_3000 + 32'(i * 4);
         exp_cmd_q.push_back({1'b0, a, 32'h0});
         master_cmd(0, 1'b0, a, 32'h0, w);
      end
      exp_cmd_q.push_back({1'b0, 32'h0000_3100, 32'h0});
      m0_address = 32'h0000_3100; m0_read = 1'b1;
      @(negedge clk);
      check("t4_bubble_wait", {31'd0, m0_waitrequest}, 32'd1);
      for (int k = 0; k < 2; k++) begin
         tick();
         @(negedge clk);
         check("t4_thr_sread", {31'd0, s_read}, 32'd0);
         check("t4_thr_wait", {31'd0, m0_waitrequest}, 32'd1);
      end
      tick();
      exp_rd_q.push_back({1'b0, 32'hB000_0000});
      s_readdata = 32'hB000_0000; s_readdatavalid = 1'b1;
      @(negedge clk);
      check("t4_thr_pop_cycle", {31'd0, s_read}, 32'd0);
      tick();
      s_readdatavalid = 1'b0;
      @(negedge clk);
      check("t4_release_sread", {31'd0, s_read}, 32'd1);
      check("t4_release_wait", {31'd0, m0_waitrequest}, 32'd0);
      tick();
      m0_read = 1'b0;
      for (int i = 1; i <= MAXP; i++) begin
         a = 32'hB000_0000 + 32'(i);
         exp_rd_q.push_back({1'b0, a});
         slave_return(a);
      end
      check("t4_rd_done", exp_rd_q.size(), 32'd0);

      // T5: spurious read return sets a sticky error
      do_reset();
      @(negedge clk);
      check("t5_err_clear", {31'd0, err_spurious}, 32'd0);
      tick();
      s_readdata = 32'h5555_AAAA; s_readdatavalid = 1'b1;
      @(negedge clk);
      check("t5_no_m0_rdv", {31'd0, m0_readdatavalid}, 32'd0);
      check("t5_no_m1_rdv", {31'd0, m1_readdatavalid}, 32'd0);
      tick();
      s_readdatavalid = 1'b0;
      @(negedge clk);
      check("t5_err_set", {31'd0, err_spurious}, 32'd1);
      tick();
      exp_cmd_q.push_back({1'b0, 32'h0000_0500, 32'h0});
      master_cmd(1, 1'b0, 32'h0000_0500, 32'h0, w);
      exp_rd_q.push_back({1'b1, 32'h7777_0500});
      slave_return(32'h7777_0500);
      @(negedge clk);
      check("t5_err_sticky", {31'd0, err_spurious}, 32'd1);
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      check("t5_err_reset", {31'd0, err_spurious}, 32'd0);
      tick();
      rst_n = 1'b1;

      // T6: reset with m1 reads outstanding, then fresh tie
      do_reset();
      for (int i = 0; i < 3; i++) begin
         a = 32'h0000_6000 + 32'(i * 4);
         exp_cmd_q.push_back({1'b0, a, 32'h0});
         master_cmd(1, 1'b0, a, 32'h0, w);
      end
      rst_n = 1'b0;
      m0_address = 32'h0000_0500; m0_read = 1'b1;
      m1_address = 32'h0000_0600; m1_read = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("t6_rst_sread", {31'd0, s_read}, 32'd0);
         check("t6_rst_swrite", {31'd0, s_write}, 32'd0);
         check("t6_rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
         check("t6_rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
         tick();
      end
      rst_n = 1'b1;
      exp_cmd_q.push_back({1'b0, 32'h0000_0500, 32'h0});
      exp_cmd_q.push_back({1'b0, 32'h0000_0600, 32'h0});
      @(negedge clk);
      check("t6_bubble_sread", {31'd0, s_read}, 32'd0);
      check("t6_bubble_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
      tick();
      @(negedge clk);
      check("t6_m0_wins_addr", s_address, 32'h0000_0500);
      check("t6_m0_accept", {31'd0, m0_waitrequest}, 32'd0);
      tick();
      m0_read = 1'b0;
      @(negedge clk);
      check("t6_m1_accept", {31'd0, m1_waitrequest}, 32'd0);
      tick();
      m1_read = 1'b0;
      exp_rd_q.push_back({1'b0, 32'hC000_0000});
      slave_return(32'hC000_0000);
      exp_rd_q.push_back({1'b1, 32'hC000_0001});
      slave_return(32'hC000_0001);
      @(negedge clk);
      check("t6_no_err", {31'd0, err_spurious}, 32'd0);
      tick();

      check("end_cmd_q", exp_cmd_q.size(), 32'd0);
      check("end_rd_q", exp_rd_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
